nn_output_layer: RTL and testbench
==================================

// Module: nn_output_layer
// PURPOSE
//  Second (output) layer of the feed-forward NN; sits directly downstream of the hidden layer.
//  - Consumes the NHID signed hidden activations (ternary -1/0/+1 in normal use).
//  - Fetches the layer-2 weight word from the shared 256-bit weight RAM.
//  - Runs one MAC step per cycle, producing NOUT signed sums, per-output sign bits and an argmax class index.
// PARAMETERS
//  WWIDTH  8    width of one signed weight
//  HWIDTH  9    width of one signed hidden activation
//  NHID    6    number of hidden inputs
//  NOUT    2    number of outputs; NOUT*NHID*WWIDTH <= 256
//  ACC_W   20   signed accumulator width; must be >= HWIDTH+WWIDTH+clog2(NHID)
//  WADDR   1    RAM address of the layer-2 weight word
// PORTS
//  clk        in   1              clock; all state updates on posedge
//  reset      in   1              synchronous, active-high
//  in_valid   in   1              hidden vector present
//  in_ready   out  1              block can accept a hidden vector
//  h_flat     in   NHID*HWIDTH    hidden value k at [(k+1)*HWIDTH-1 : k*HWIDTH], signed
//  mem_addr   out  4              weight RAM address (constant WADDR)
//  mem_rd     out  1              read strobe; RAM returns the word one cycle later
//  mem_rdata  in   256            registered RAM output
//  out_valid  out  1              result available
//  out_ready  in   1              consumer accepts result
//  acc_flat   out  NOUT*ACC_W     sum for output j at [(j+1)*ACC_W-1 : j*ACC_W], signed
//  y          out  NOUT           y[j] = (acc_j > 0)
//  cls        out  clog2(NOUT)    index of the largest acc_j; ties resolve to the lowest index
// BEHAVIOUR
//  - Reset values: in_ready=0 during reset, then 1; out_valid=0; mem_rd=0; acc_flat/y/cls=0.
//    FSM enters IDLE; MAC index k=0; cache-valid flag cleared.
//  - FSM states: IDLE -> FETCH -> LOAD -> MAC -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid & in_ready (cycle T):
//    - register h_flat;
//    - clear all accumulators;
//    - go to FETCH.
//  - FETCH (T+1): mem_rd=1, mem_addr=WADDR; go to LOAD.
//  - LOAD (T+2): register mem_rdata as the weight word; go to MAC.
//  - Weight layout: w(j,k) = word[(j*NHID+k+1)*WWIDTH-1 : (j*NHID+k)*WWIDTH], signed.
//  - MAC (T+3 .. T+2+NHID): each cycle, for every j in parallel, acc_j += h_k * w(j,k).
//    - h_k and w(j,k) are sign-extended to ACC_W; the product is full precision.
//    - k increments each cycle; after k=NHID-1, go to DONE.
//    - Default sizing cannot overflow: worst case 6 * (-256 * -128) = 196608 < 2^19.
//  - DONE: out_valid=1 from T+3+NHID (T+9 at default), 9-cycle latency.
//    - acc_flat, y and cls are registered and stay stable while out_valid=1.
//    - On out_ready=1, out_valid drops the next cycle and the FSM returns to IDLE.
//  - in_ready=0 in every state except IDLE. No new input is accepted while a result is held.
//  - in_valid with reset asserted is ignored.
//  - Reset asserted in any state aborts the transaction and restores all reset values in the next cycle.
//  - mem_rdata is sampled only in LOAD; it is don't-care in all other states.
// CONFIGURATION
//  NN_OUTL_WCACHE_EN defined:
//    - The first transaction after reset fetches the weights (FETCH/LOAD) and sets the cache-valid flag.
//    - Later transactions go IDLE -> MAC directly with mem_rd=0.
//    - Latency is 7 cycles (out_valid at T+1+NHID).
//  NN_OUTL_WCACHE_EN undefined:
//    - Every transaction refetches the weight word; latency is always 9 cycles.
// TESTING
//  1 All h=+1; w(0,k)=+2, w(1,k)=-1 -> out_valid at T+9, acc0=12, acc1=-6, y=2'b01, cls=0.
//  2 All h=0; any weights -> acc0=acc1=0, y=2'b00, cls=0 (tie goes to lowest index).
//  3 All h=-256; all w=-128 -> acc0=acc1=196608, y=2'b11, cls=0, no wrap.
//  4 out_ready held low 5 cycles after out_valid -> out_valid, acc_flat, y and cls stable; in_ready=0 throughout.
//  5 reset pulsed during the 3rd MAC cycle -> next cycle out_valid=0, acc_flat=0;
//    a fresh transaction then gives the correct result.
//  6 (WCACHE_EN) two back-to-back transactions -> first latency 9 with one mem_rd pulse,
//    second latency 7 with no mem_rd pulse.

Source files
------------

// File: rtl/nn_output_layer.sv
// Output layer of the feed-forward NN: fetches one weight word, runs NHID MAC steps over the hidden vector,
// and reports per-output sums, sign bits and an argmax class. Optional weight cache: NN_OUTL_WCACHE_EN.
module nn_output_layer #(
    parameter int unsigned WWIDTH = 8,
    parameter int unsigned HWIDTH = 9,
    parameter int unsigned NHID   = 6,
    parameter int unsigned NOUT   = 2,
    parameter int unsigned ACC_W  = 20,
    parameter int unsigned WADDR  = 1,
    localparam int unsigned CLS_W = (NOUT > 1) ? $clog2(NOUT) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NHID*HWIDTH-1:0]  h_flat,
    output logic [3:0]              mem_addr,
    output logic                    mem_rd,
    input  logic [255:0]            mem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NOUT*ACC_W-1:0]   acc_flat,
    output logic [NOUT-1:0]         y,
    output logic [CLS_W-1:0]        cls
);

    localparam int unsigned K_W   = (NHID > 1) ? $clog2(NHID) : 1;
    localparam int unsigned WBITS = NOUT * NHID * WWIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_MAC,
        S_DONE
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [K_W-1:0]             r_k;
    logic [NHID*HWIDTH-1:0]     r_h;
    logic [WBITS-1:0]           r_w;
    logic signed [ACC_W-1:0]    r_acc [NOUT];
`ifdef NN_OUTL_WCACHE_EN
    logic                       r_wvalid;
`endif

    logic                       w_accept;
    logic                       w_last;
    logic signed [HWIDTH-1:0]   w_h_k;
    logic signed [ACC_W-1:0]    w_hx;
    logic signed [WWIDTH-1:0]   w_wt  [NOUT];
    logic signed [ACC_W-1:0]    w_wx  [NOUT];
    logic signed [ACC_W-1:0]    w_sum [NOUT];
    logic signed [ACC_W-1:0]    w_best;
    logic [NOUT-1:0]            w_y;
    logic [CLS_W-1:0]           w_cls;

    assign mem_addr = 4'(WADDR);
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_k == K_W'(NHID - 1));

    generate
        if (WBITS < 256) begin : g_spare
            logic w_unused_rdata;
            assign w_unused_rdata = ^mem_rdata[255:WBITS];
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
`ifdef NN_OUTL_WCACHE_EN
                    w_next = r_wvalid ? S_MAC : S_FETCH;
`else
                    w_next = S_FETCH;
`endif
                end
            end
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_MAC;
            S_MAC:   if (w_last) w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // One MAC step for all outputs in parallel, plus sign bits and argmax of the updated sums
    always_comb begin
        w_h_k  = r_h[32'(r_k) * HWIDTH +: HWIDTH];
        w_hx   = {{(ACC_W - HWIDTH){w_h_k[HWIDTH-1]}}, w_h_k};
        w_y    = '0;
        w_cls  = '0;
        for (int j = 0; j < int'(NOUT); j++) begin
            w_wt[j]  = r_w[(32'(j) * NHID + 32'(r_k)) * WWIDTH +: WWIDTH];
            w_wx[j]  = {{(ACC_W - WWIDTH){w_wt[j][WWIDTH-1]}}, w_wt[j]};
            w_sum[j] = r_acc[j] + w_hx * w_wx[j];
            w_y[j]   = !w_sum[j][ACC_W-1] && (w_sum[j] != '0);
        end
        w_best = w_sum[0];
        // Strict compare keeps ties on the lowest index
        for (int j = 1; j < int'(NOUT); j++) begin
            if (w_sum[j] > w_best) begin
                w_best = w_sum[j];
                w_cls  = CLS_W'(j);
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_k       <= '0;
            r_h       <= '0;
            r_w       <= '0;
            for (int j = 0; j < int'(NOUT); j++) r_acc[j] <= '0;
`ifdef NN_OUTL_WCACHE_EN
            r_wvalid  <= 1'b0;
`endif
            in_ready  <= 1'b0;
            mem_rd    <= 1'b0;
            out_valid <= 1'b0;
            acc_flat  <= '0;
            y         <= '0;
            cls       <= '0;
        end else begin
            in_ready  <= (w_next == S_IDLE);
            mem_rd    <= (w_next == S_FETCH);
            out_valid <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_h <= h_flat;
                        r_k <= '0;
                        for (int j = 0; j < int'(NOUT); j++) r_acc[j] <= '0;
                    end
                end
                S_LOAD: begin
                    r_w <= mem_rdata[WBITS-1:0];
`ifdef NN_OUTL_WCACHE_EN
                    r_wvalid <= 1'b1;
`endif
                end
                S_MAC: begin
                    r_k <= r_k + K_W'(1);
                    for (int j = 0; j < int'(NOUT); j++) r_acc[j] <= w_sum[j];
                    if (w_last) begin
                        for (int j = 0; j < int'(NOUT); j++) acc_flat[j*ACC_W +: ACC_W] <= w_sum[j];
                        y   <= w_y;
                        cls <= w_cls;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_output_layer.sv
// Randomized self-checking bench for nn_output_layer with a registered weight-RAM model and
// an arithmetic reference model; expectations follow NN_OUTL_WCACHE_EN when defined.
module tb_nn_output_layer;

    localparam int unsigned HW = 9;
    localparam int unsigned WW = 8;
    localparam int unsigned NH = 6;
    localparam int unsigned NO = 2;
    localparam int unsigned AW = 20;

    logic                 clk;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [NH*HW-1:0]     h_flat;
    logic [3:0]           mem_addr;
    logic                 mem_rd;
    logic [255:0]         mem_rdata;
    logic                 out_valid;
    logic                 out_ready;
    logic [NO*AW-1:0]     acc_flat;
    logic [NO-1:0]        y;
    logic                 cls;

    int          n_checks;
    int          n_fails;
    logic [255:0] tb_word;
    logic [255:0] cached_word;
    bit           tb_cached;

    nn_output_layer dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .h_flat    (h_flat),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_flat  (acc_flat),
        .y         (y),
        .cls       (cls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered RAM: address 1 holds tb_word; anything else reads as noise
    always @(posedge clk) begin
        if (mem_rd && mem_addr == 4'd1)
            mem_rdata <= tb_word;
        else
            mem_rdata <= {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
    end

    function automatic void model(input logic [NH*HW-1:0] h, input logic [255:0] w,
                                  output logic [NO*AW-1:0] acc, output logic [NO-1:0] yy,
                                  output logic cc);
        int s [NO];
        logic signed [HW-1:0] hv;
        logic signed [WW-1:0] wv;
        for (int j = 0; j < int'(NO); j++) begin
            s[j] = 0;
            for (int k = 0; k < int'(NH); k++) begin
                hv = h[k*HW +: HW];
                wv = w[(j*NH + k)*WW +: WW];
                s[j] += int'(hv) * int'(wv);
            end
            acc[j*AW +: AW] = AW'(s[j]);
            yy[j] = (s[j] > 0);
        end
        cc = (s[1] > s[0]);
    endfunction

    function automatic logic [NH*HW-1:0] fill_h(input int v);
        logic [NH*HW-1:0] h;
        for (int k = 0; k < int'(NH); k++) h[k*HW +: HW] = HW'(v);
        return h;
    endfunction

    function automatic logic [NH*HW-1:0] rand_h(input bit ternary);
        logic [NH*HW-1:0] h;
        for (int k = 0; k < int'(NH); k++)
            h[k*HW +: HW] = ternary ? HW'(int'($urandom_range(0, 2)) - 1) : HW'($urandom);
        return h;
    endfunction

    function automatic logic [255:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction: issue, measure latency and fetches, check result, hold, release
    task automatic do_txn(input logic [NH*HW-1:0] h, input int hold, input string name);
        logic [255:0]     wexp;
        logic [NO*AW-1:0] ea;
        logic [NO-1:0]    ey;
        logic             ec;
        int               exp_lat, exp_rd, lat, rd, bad_addr;
`ifdef NN_OUTL_WCACHE_EN
        if (!tb_cached) begin
            cached_word = tb_word;
            tb_cached   = 1'b1;
            exp_lat     = 9;
            exp_rd      = 1;
        end else begin
            exp_lat = 7;
            exp_rd  = 0;
        end
        wexp = cached_word;
`else
        wexp    = tb_word;
        exp_lat = 9;
        exp_rd  = 1;
`endif
        model(h, wexp, ea, ey, ec);
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", name, in_ready);
        end
        in_valid = 1'b1;
        h_flat   = h;
        @(posedge clk); #1;
        in_valid = 1'b0;
        h_flat   = rand_h(1'b0);
        lat = 1; rd = 0; bad_addr = 0;
        while (!out_valid && lat < 40) begin
            if (mem_rd) begin
                rd++;
                if (mem_addr !== 4'd1) bad_addr++;
            end
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL %s busy_ready: in_ready=%b required 0 at T+%0d", name, in_ready, lat);
            end
            @(posedge clk); #1; lat++;
        end
        n_checks++;
        if (lat !== exp_lat) begin
            n_fails++;
            $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
        end
        n_checks++;
        if (rd !== exp_rd || bad_addr !== 0) begin
            n_fails++;
            $display("FAIL %s mem_rd: pulses=%0d bad_addr=%0d required pulses=%0d bad_addr=0",
                     name, rd, bad_addr, exp_rd);
        end
        for (int c = 0; c <= hold; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || acc_flat !== ea || y !== ey || cls !== ec || in_ready !== 1'b0) begin
                n_fails++;
                $display("FAIL %s result[%0d]: ov=%b acc=%h y=%b cls=%b rdy=%b required ov=1 acc=%h y=%b cls=%b rdy=0",
                         name, c, out_valid, acc_flat, y, cls, in_ready, ea, ey, ec);
            end
            if (c < hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL %s release: out_valid=%b in_ready=%b required 0 and 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b1;
        h_flat   = fill_h(1);
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || mem_rd !== 1'b0 ||
            acc_flat !== '0 || y !== '0 || cls !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_state: rdy=%b ov=%b rd=%b acc=%h y=%b cls=%b required all 0",
                     in_ready, out_valid, mem_rd, acc_flat, y, cls);
        end
        in_valid  = 1'b0;
        reset     = 1'b0;
        tb_cached = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_release: in_ready=%b required 1", in_ready);
        end
        repeat (12) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fails++;
            $display("FAIL reset_ignored_valid: out_valid=%b in_ready=%b required 0 and 1", out_valid, in_ready);
        end
    endtask

    task automatic test_directed();
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < int'(NH); k++) begin
            w[k*WW +: WW]        = 8'sd2;
            w[(NH + k)*WW +: WW] = -8'sd1;
        end
        w[255:96] = rand_word();
        tb_word = w;
        do_txn(fill_h(1), 0, "ones");
        tb_word = rand_word();
        do_txn(fill_h(0), 0, "zeros");
        w = '0;
        for (int k = 0; k < int'(2*NH); k++) w[k*WW +: WW] = 8'h80;
        tb_word = w;
        do_txn(fill_h(-256), 0, "extreme");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            tb_word = rand_word();
            do_txn(rand_h(i[0]), int'($urandom_range(0, 2)), "random");
        end
    endtask

    task automatic test_backpressure();
        tb_word = rand_word();
        do_txn(rand_h(1'b1), 5, "backpressure");
    endtask

    task automatic test_reset_mid();
        int mac3;
        mac3 = 5;
`ifdef NN_OUTL_WCACHE_EN
        if (tb_cached) mac3 = 3;
`endif
        tb_word  = rand_word();
        in_valid = 1'b1;
        h_flat   = rand_h(1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (mac3 - 1) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (out_valid !== 1'b0 || acc_flat !== '0 || y !== '0 || cls !== 1'b0 || in_ready !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_mid: ov=%b acc=%h y=%b cls=%b rdy=%b required all 0",
                     out_valid, acc_flat, y, cls, in_ready);
        end
        reset     = 1'b0;
        tb_cached = 1'b0;
        @(posedge clk); #1;
        tb_word = rand_word();
        do_txn(rand_h(1'b0), 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        tb_word = rand_word();
        do_txn(rand_h(1'b1), 0, "b2b_first");
        tb_word = rand_word();
        do_txn(rand_h(1'b0), 0, "b2b_second");
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        tb_cached = 1'b0;
        tb_word   = '0;
        cached_word = '0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        h_flat    = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
